mc_sequencer: RTL and testbench
===============================

Name: mc_sequencer

Overview:
- Multi-cycle control FSM for the MIPS datapath: steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives per-state enables and mux selects for PC, IR, GRF, ALU and DM.
- Handshakes with instruction and data memory that may insert wait states.
- Sits beside the datapath; takes op/func from the datapath IR register and cmp_eq from the datapath comparator.

Parameters:
TIMEOUT, 16, max cycles to wait for im_ready/dm_ready before aborting; range 1..255.
RETIRE_W, 32, width of retired-instruction counter (optional feature only).

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
op  input  6  IR[31:26]
func  input  6  IR[5:0]
cmp_eq  input  1  GRF[rs]==GRF[rt], valid in EXEC
im_ready  input  1  instruction word valid this cycle
dm_ready  input  1  data access complete this cycle
state  output  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4
im_req  output  1  instruction fetch request
ir_we  output  1  load IR
pc_we  output  1  load PC
pc_sel  output  2  0 PC+4, 1 branch target, 2 jump target, 3 GRF[rs]
grf_we  output  1  register file write
reg_dst  output  2  0 rd, 1 rt, 2 $31
wd_sel  output  2  0 ALU, 1 DM, 2 imm<<16, 3 saved PC+4
alu_op  output  2  0 add, 1 sub, 2 or, 3 sll
alu_b_sel  output  1  0 rt, 1 imm32
sign_ext  output  1  1 sign-extend imm16, 0 zero-extend
dm_req  output  1  data memory request
dm_we  output  1  data memory write, only with dm_req
bus_err  output  1  one-cycle pulse on handshake timeout
illegal  output  1  one-cycle pulse in DECODE on unsupported encoding

Behaviour:
- Supported instructions: addu, subu, sll, jr, ori, lw, sw, lui, beq, j, jal. sll is op 0/func 0, so nop executes as sll.
- Only state is registered; all other outputs are combinational from state, op, func and the ready inputs.
- While reset is low: state=FETCH, wait counter=0, every output except state is forced to 0.
- FETCH:
  - im_req=1.
  - On im_ready: ir_we=1, pc_we=1, pc_sel=0, then go to DECODE. The datapath latches PC+4 for jal.
  - Otherwise stay and increment the wait counter.
- DECODE (1 cycle):
  - j: pc_we=1, pc_sel=2, go to FETCH.
  - jr: pc_we=1, pc_sel=3, go to FETCH.
  - jal: pc_we=1, pc_sel=2, go to WB.
  - Unsupported encoding: illegal=1, go to FETCH, no architectural write.
  - All others: go to EXEC.
- EXEC (1 cycle):
  - beq: alu_op=1, sign_ext=1, pc_we=cmp_eq, pc_sel=1, go to FETCH.
  - lw/sw: alu_op=0, alu_b_sel=1, sign_ext=1, go to MEM.
  - addu/subu/sll/ori/lui: go to WB. ori is zero-extended with alu_op=2.
- MEM:
  - dm_req=1; dm_we=1 for sw.
  - On dm_ready: sw goes to FETCH, lw goes to WB.
  - Otherwise stay and increment the wait counter.
- WB (1 cycle), grf_we=1 with:
  - R-type: reg_dst=0, wd_sel=0.
  - ori: reg_dst=1, wd_sel=0.
  - lui: reg_dst=1, wd_sel=2.
  - lw: reg_dst=1, wd_sel=1.
  - jal: reg_dst=2, wd_sel=3.
  - Then go to FETCH.
- Select outputs keep the decoded instruction's values in every state and are 0 for non-applicable instructions. Enables (ir_we, pc_we, grf_we, dm_req, dm_we, im_req) are asserted only as listed above.
- Wait counter:
  - Cleared on every state change.
  - If it reaches TIMEOUT while still waiting in FETCH or MEM: bus_err=1 for that cycle, go to FETCH, no pc_we/ir_we/grf_we.
  - A ready arriving in the same cycle as the timeout wins; no bus_err.
- Latency with zero wait states, in cycles: j/jr 2, beq/jal 3, sw/ALU ops 4, lw 5.
- Reset asserted mid-instruction aborts it immediately. After release the first cycle is FETCH with im_req=1.

Optional Feature:
- Macro MC_RETIRE_CNT_EN.
- When defined:
  - Adds output retired[RETIRE_W-1:0], reset to 0.
  - Increments by 1 on the final cycle of each completed instruction: j/jr in DECODE, beq in EXEC, sw on the MEM cycle with dm_ready, others in WB.
  - No increment on illegal or bus_err. Wraps modulo 2^RETIRE_W.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- addu (op 0, func 0x21), zero-wait memory: states 0,1,2,4,0; grf_we=1 only in cycle 4 with reg_dst=0, wd_sel=0.
- lw (op 0x23), dm_ready low 3 cycles: MEM held 4 cycles with dm_req=1, dm_we=0; then WB with wd_sel=1, reg_dst=1; total 8 cycles.
- beq (op 0x04) with cmp_eq=1, then again with cmp_eq=0: pc_we=1/pc_sel=1 in EXEC for the first, pc_we=0 for the second; both return to FETCH after 3 cycles.
- jal (op 0x03): DECODE pc_we=1, pc_sel=2; WB grf_we=1, reg_dst=2, wd_sel=3.
- im_ready held low, TIMEOUT=16: bus_err pulses on the 17th FETCH cycle with no ir_we. Separately, op 0x3F pulses illegal in DECODE with no writes.
- Reset asserted during MEM of sw: dm_req drops immediately; after release state=0, im_req=1. With MC_RETIRE_CNT_EN, retired is 0 after reset and 1 after one completed addu.

Source files
------------

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with memory handshake timeout.
// Define MC_RETIRE_CNT_EN to add the retired-instruction counter output.
module mc_sequencer #(
  parameter int TIMEOUT = 16
`ifdef MC_RETIRE_CNT_EN
  , parameter int RETIRE_W = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       cmp_eq,
  input  logic       im_ready,
  input  logic       dm_ready,
  output logic [2:0] state,
  output logic       im_req,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       grf_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic [1:0] alu_op,
  output logic       alu_b_sel,
  output logic       sign_ext,
  output logic       dm_req,
  output logic       dm_we,
  output logic       bus_err,
  output logic       illegal
`ifdef MC_RETIRE_CNT_EN
  , output logic [RETIRE_W-1:0] retired
`endif
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} st_t;
  st_t st, nxt;
  logic [7:0] cnt;
  logic rtype, is_addu, is_subu, is_sll, is_jr, is_ori, is_lw, is_sw, is_lui, is_beq, is_j, is_jal, legal;
  logic waiting, tmo;
  assign rtype   = op == 6'h00;
  assign is_addu = rtype && func == 6'h21;
  assign is_subu = rtype && func == 6'h23;
  assign is_sll  = rtype && func == 6'h00;
  assign is_jr   = rtype && func == 6'h08;
  assign is_ori  = op == 6'h0d;
  assign is_lw   = op == 6'h23;
  assign is_sw   = op == 6'h2b;
  assign is_lui  = op == 6'h0f;
  assign is_beq  = op == 6'h04;
  assign is_j    = op == 6'h02;
  assign is_jal  = op == 6'h03;
  assign legal   = is_addu || is_subu || is_sll || is_jr || is_ori || is_lw || is_sw ||
                   is_lui || is_beq || is_j || is_jal;
  assign waiting = (st == FETCH && !im_ready) || (st == MEM && !dm_ready);
  assign tmo     = waiting && cnt == 8'(TIMEOUT);
  always_comb begin
    nxt = FETCH;
    case (st)
      FETCH:   nxt = im_ready ? DECODE : FETCH;
      DECODE:  nxt = (!legal || is_j || is_jr) ? FETCH : is_jal ? WB : EXEC;
      EXEC:    nxt = is_beq ? FETCH : (is_lw || is_sw) ? MEM : WB;
      MEM:     nxt = dm_ready ? (is_sw ? FETCH : WB) : tmo ? FETCH : MEM;
      WB:      nxt = FETCH;
      default: nxt = FETCH;
    endcase
  end
  // a timeout restarts the wait window even when the state stays FETCH
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st  <= FETCH;
      cnt <= 8'd0;
    end else begin
      st  <= nxt;
      cnt <= (nxt != st || tmo) ? 8'd0 : waiting ? cnt + 8'd1 : cnt;
    end
  assign state     = st;
  assign im_req    = reset && st == FETCH;
  assign ir_we     = reset && st == FETCH && im_ready;
  assign pc_we     = reset && ((st == FETCH && im_ready) || (st == DECODE && (is_j || is_jr || is_jal)) ||
                               (st == EXEC && is_beq && cmp_eq));
  assign grf_we    = reset && st == WB;
  assign dm_req    = reset && st == MEM;
  assign dm_we     = dm_req && is_sw;
  assign bus_err   = reset && tmo;
  assign illegal   = reset && st == DECODE && !legal;
  assign pc_sel    = (!reset || st == FETCH) ? 2'd0 : (is_j || is_jal) ? 2'd2 : is_jr ? 2'd3 :
                     is_beq ? 2'd1 : 2'd0;
  assign reg_dst   = !reset ? 2'd0 : is_jal ? 2'd2 : (is_ori || is_lui || is_lw) ? 2'd1 : 2'd0;
  assign wd_sel    = !reset ? 2'd0 : is_jal ? 2'd3 : is_lui ? 2'd2 : is_lw ? 2'd1 : 2'd0;
  assign alu_op    = !reset ? 2'd0 : (is_subu || is_beq) ? 2'd1 : is_ori ? 2'd2 : is_sll ? 2'd3 : 2'd0;
  assign alu_b_sel = reset && (is_ori || is_lw || is_sw);
  assign sign_ext  = reset && (is_beq || is_lw || is_sw);
`ifdef MC_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) retired <= '0;
    else if ((st == DECODE && (is_j || is_jr)) || (st == EXEC && is_beq) ||
             (st == MEM && is_sw && dm_ready) || st == WB)
      retired <= retired + 1'b1;
`endif
endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: expected per-cycle outputs are generated per instruction from its class
// (path through the phases, wait states, selects table) and compared cycle by cycle.
module tb_mc_sequencer;
  localparam int TO = 16;
  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4;
  localparam logic [7:0] IMQ = 8'h80, IRW = 8'h40, PCW = 8'h20, GRF = 8'h10,
                         DMQ = 8'h08, DMW = 8'h04, BERR = 8'h02, ILL = 8'h01;
  // kinds: 0 addu 1 subu 2 sll 3 jr 4 ori 5 lw 6 sw 7 lui 8 beq 9 j 10 jal 11 illegal
  localparam int RD[12] = '{0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 2, 0};
  localparam int WD[12] = '{0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 3, 0};
  localparam int AO[12] = '{0, 1, 3, 0, 2, 0, 0, 0, 1, 0, 0, 0};
  localparam int AB[12] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
  localparam int SX[12] = '{0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0};
  localparam int PS[12] = '{0, 0, 0, 3, 0, 0, 0, 0, 1, 2, 2, 0};
  localparam logic [11:0] ENC[14] = '{{6'h00, 6'h21}, {6'h00, 6'h23}, {6'h00, 6'h00}, {6'h00, 6'h08},
                                      {6'h0d, 6'h00}, {6'h23, 6'h00}, {6'h2b, 6'h00}, {6'h0f, 6'h00},
                                      {6'h04, 6'h00}, {6'h02, 6'h00}, {6'h03, 6'h00}, {6'h3f, 6'h00},
                                      {6'h00, 6'h20}, {6'h08, 6'h00}};
  typedef struct {
    logic [5:0] op, func;
    logic       cmp, imr, dmr;
    logic [2:0] st;
    logic [7:0] en;
    logic [1:0] pc_sel, reg_dst, wd_sel, alu_op;
    logic       alu_b, sext, ret;
  } vec_t;
  logic clk = 0, reset = 0, cmp_eq = 0, im_ready = 0, dm_ready = 0;
  logic [5:0] op = 0, func = 0;
  logic [2:0] state;
  logic im_req, ir_we, pc_we, grf_we, alu_b_sel, sign_ext, dm_req, dm_we, bus_err, illegal;
  logic [1:0] pc_sel, reg_dst, wd_sel, alu_op;
`ifdef MC_RETIRE_CNT_EN
  logic [31:0] retired;
`endif
  vec_t q[$];
  int n_chk = 0, n_fail = 0;
  logic [31:0] ret_model = 0;
  always #5 clk = ~clk;
  mc_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .cmp_eq(cmp_eq), .im_ready(im_ready),
    .dm_ready(dm_ready), .state(state), .im_req(im_req), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .grf_we(grf_we), .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_op(alu_op),
    .alu_b_sel(alu_b_sel), .sign_ext(sign_ext), .dm_req(dm_req), .dm_we(dm_we),
    .bus_err(bus_err), .illegal(illegal)
`ifdef MC_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );
  function automatic logic [20:0] act();
    return {state, im_req, ir_we, pc_we, grf_we, dm_req, dm_we, bus_err, illegal,
            pc_sel, reg_dst, wd_sel, alu_op, alu_b_sel, sign_ext};
  endfunction
  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask
  function automatic int kind_of(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00) return f == 6'h21 ? 0 : f == 6'h23 ? 1 : f == 6'h00 ? 2 : f == 6'h08 ? 3 : 11;
    case (o)
      6'h0d: return 4;
      6'h23: return 5;
      6'h2b: return 6;
      6'h0f: return 7;
      6'h04: return 8;
      6'h02: return 9;
      6'h03: return 10;
      default: return 11;
    endcase
  endfunction
  task automatic push(input vec_t b, input logic [2:0] s, input logic [7:0] en,
                      input logic imr, input logic dmr, input logic ret);
    vec_t v = b;
    v.st = s; v.en = en; v.imr = imr; v.dmr = dmr; v.ret = ret;
    q.push_back(v);
  endtask
  // expected cycles of one instruction; wait counts above TO end in a bus error
  task automatic gen(input logic [5:0] o, input logic [5:0] f, input logic c, input int imw, input int dmw);
    int k;
    vec_t b;
    logic [7:0] en;
    k = kind_of(o, f);
    b = '{default: 0};
    b.op = o; b.func = f; b.cmp = c;
    b.reg_dst = 2'(RD[k]); b.wd_sel = 2'(WD[k]); b.alu_op = 2'(AO[k]);
    b.alu_b = AB[k] != 0; b.sext = SX[k] != 0;
    for (int i = 0; i < imw && i < TO; i++) push(b, S_F, IMQ, 0, 0, 0);
    if (imw > TO) begin push(b, S_F, IMQ | BERR, 0, 0, 0); return; end
    push(b, S_F, IMQ | IRW | PCW, 1, 0, 0);
    b.pc_sel = 2'(PS[k]);
    if (k == 11) begin push(b, S_D, ILL, 0, 0, 0); return; end
    if (k == 3 || k == 9) begin push(b, S_D, PCW, 0, 0, 1); return; end
    if (k == 10) begin push(b, S_D, PCW, 0, 0, 0); push(b, S_W, GRF, 0, 0, 1); return; end
    push(b, S_D, 8'h00, 0, 0, 0);
    if (k == 8) begin push(b, S_E, c ? PCW : 8'h00, 0, 0, 1); return; end
    push(b, S_E, 8'h00, 0, 0, 0);
    if (k == 5 || k == 6) begin
      en = DMQ | (k == 6 ? DMW : 8'h00);
      for (int i = 0; i < dmw && i < TO; i++) push(b, S_M, en, 0, 0, 0);
      if (dmw > TO) begin push(b, S_M, en | BERR, 0, 0, 0); return; end
      push(b, S_M, en, 0, 1, k == 6);
      if (k == 6) return;
    end
    push(b, S_W, GRF, 0, 0, 1);
  endtask
  task automatic step(input vec_t v);
    logic [20:0] x, m;
    @(negedge clk);
    op = v.op; func = v.func; cmp_eq = v.cmp; im_ready = v.imr; dm_ready = v.dmr;
    #1;
    x = {v.st, v.en, v.pc_sel, v.reg_dst, v.wd_sel, v.alu_op, v.alu_b, v.sext};
    m = {11'h7ff, {2{v.en[5]}}, {4{v.en[4]}}, {4{v.st == S_E}}};
    cmp("cycle", 64'(act() & m), 64'(x & m));
`ifdef MC_RETIRE_CNT_EN
    cmp("retired", 64'(retired), 64'(ret_model));
`endif
    if (v.ret) ret_model++;
  endtask
  task automatic run_q();
    while (q.size() > 0) step(q.pop_front());
  endtask
  initial begin
    im_ready = 1; dm_ready = 1; op = 6'h23; cmp_eq = 1;
    repeat (3) begin
      @(negedge clk); #1;
      cmp("reset_outputs", 64'(act()), 64'd0);
`ifdef MC_RETIRE_CNT_EN
      cmp("reset_retired", 64'(retired), 64'd0);
`endif
    end
    im_ready = 0; dm_ready = 0; reset = 1;
    gen(6'h00, 6'h21, 0, 0, 0);
    gen(6'h23, 6'h00, 0, 0, 3);
    gen(6'h04, 6'h00, 1, 0, 0);
    gen(6'h04, 6'h00, 0, 0, 0);
    gen(6'h03, 6'h00, 0, 0, 0);
    gen(6'h00, 6'h21, 0, 17, 0);
    gen(6'h3f, 6'h00, 0, 0, 0);
    gen(6'h0f, 6'h00, 0, 16, 0);
    gen(6'h2b, 6'h00, 0, 1, 17);
    gen(6'h2b, 6'h00, 0, 0, 16);
    gen(6'h00, 6'h08, 0, 2, 0);
    gen(6'h0d, 6'h00, 0, 0, 0);
    run_q();
    gen(6'h2b, 6'h00, 0, 0, 10);
    repeat (4) step(q.pop_front());
    q.delete();
    reset = 0; ret_model = 0;
    #1;
    cmp("async_reset", 64'(act()), 64'd0);
`ifdef MC_RETIRE_CNT_EN
    cmp("async_reset_retired", 64'(retired), 64'd0);
`endif
    @(negedge clk);
    reset = 1; im_ready = 0; dm_ready = 0;
    #1;
    cmp("post_release", 64'({state, im_req}), 64'(4'b0001));
    gen(6'h00, 6'h21, 0, 0, 0);
    run_q();
    for (int n = 0; n < 80; n++) begin
      int idx;
      int imw, dmw;
      idx = $urandom_range(0, 13);
      imw = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 18) : $urandom_range(0, 3);
      dmw = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 18) : $urandom_range(0, 3);
      gen(ENC[idx][11:6], ENC[idx][5:0], 1'($urandom), imw, dmw);
      run_q();
    end
    @(negedge clk);
    op = 6'h00; func = 6'h21; im_ready = 0;
    #1;
    cmp("final_state", 64'({state, im_req}), 64'(4'b0001));
`ifdef MC_RETIRE_CNT_EN
    cmp("final_retired", 64'(retired), 64'(ret_model));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
